// File: rtl/avg_frame_packer_if.sv
// Byte-stream link between the frame packer and the UART/host side.
// The master presents a byte with valid and last. The slave accepts it with ready.
interface avg_frame_packer_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/avg_frame_packer.sv
// Frame packer behind the moving-average filter.
// Filter output samples are buffered in a small FIFO. When a full frame is
// buffered, the frame is sent as: HEADER, seq, {hi, lo} per sample, checksum.
// The checksum is (seq + all data bytes) mod 256.
// Every stream output is registered. The next byte is loaded on the same edge
// that accepts the current byte, so a stalled byte never changes.
module avg_frame_packer #(
    parameter int         FRAME_LEN  = 8,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          sample_valid,
    input  logic signed [15:0]            sample_in,
    avg_frame_packer_if.master            m,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] LEVEL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LEVEL_FRAME = LW'(FRAME_LEN);
    localparam logic [LW-1:0] LAST_SMP    = LW'(FRAME_LEN - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_SEQ  = 3'd2;
    localparam logic [2:0] S_HI   = 3'd3;
    localparam logic [2:0] S_LO   = 3'd4;
    localparam logic [2:0] S_CHK  = 3'd5;

    // Running frame checksum: 8-bit wrap-around addition.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        csum_add = acc + b;
    endfunction

    // Sample storage and pointers
    logic signed [15:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [7:0]         head_hi;
    logic [7:0]         head_lo;
    logic [7:0]         next_hi;

    // Frame control state
    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [7:0]    seq;
    logic [7:0]    seq_nxt;
    logic [LW-1:0] smp_cnt;
    logic [LW-1:0] smp_cnt_nxt;
    logic [7:0]    chk_acc;
    logic [7:0]    chk_nxt;

    // Next values of the registered stream outputs
    logic [7:0] data_nxt;
    logic       valid_nxt;
    logic       last_nxt;

    logic accept;
    logic wr_en;
    logic drop;
    logic pop;
    logic frame_ready;

    // Fullness is taken from the registered level, so a same-cycle pop does
    // not make room for a sample that arrives while the FIFO is full.
    assign accept      = m.m_valid && m.m_ready;
    assign wr_en       = enable && sample_valid && (fifo_level != LEVEL_FULL);
    assign drop        = enable && sample_valid && (fifo_level == LEVEL_FULL);
    assign pop         = accept && (state == S_LO);
    assign frame_ready = (fifo_level >= LEVEL_FRAME);

    // The oldest sample, and the sample behind it. The LO byte pops the
    // oldest sample, so the next HI byte must come from the following sample.
    assign head_hi = mem[rd_ptr][15:8];
    assign head_lo = mem[rd_ptr][7:0];
    assign next_hi = mem[rd_ptr + AW'(1)][15:8];

    // Sample storage write. This holds data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    // FIFO pointers and occupancy. The level updates on the write/pop edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky overflow flag. A drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    // Frame sequencing. When a byte is accepted, choose the next state and the
    // next byte to present.
    always_comb begin
        state_nxt   = state;
        seq_nxt     = seq;
        smp_cnt_nxt = smp_cnt;
        chk_nxt     = chk_acc;
        data_nxt    = m.m_data;
        valid_nxt   = m.m_valid;
        last_nxt    = m.m_last;

        case (state)
            S_IDLE: begin
                if (frame_ready) begin
                    state_nxt = S_HDR;
                    data_nxt  = HEADER;
                    valid_nxt = 1'b1;
                    last_nxt  = 1'b0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    state_nxt = S_SEQ;
                    data_nxt  = seq;
                    chk_nxt   = seq;
                end
            end
            S_SEQ: begin
                if (accept) begin
                    state_nxt   = S_HI;
                    data_nxt    = head_hi;
                    chk_nxt     = csum_add(chk_acc, head_hi);
                    smp_cnt_nxt = '0;
                end
            end
            S_HI: begin
                if (accept) begin
                    state_nxt = S_LO;
                    data_nxt  = head_lo;
                    chk_nxt   = csum_add(chk_acc, head_lo);
                end
            end
            S_LO: begin
                if (accept) begin
                    if (smp_cnt == LAST_SMP) begin
                        state_nxt = S_CHK;
                        data_nxt  = chk_acc;
                        last_nxt  = 1'b1;
                    end else begin
                        state_nxt   = S_HI;
                        data_nxt    = next_hi;
                        chk_nxt     = csum_add(chk_acc, next_hi);
                        smp_cnt_nxt = smp_cnt + LW'(1);
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    seq_nxt  = seq + 8'd1;
                    last_nxt = 1'b0;
                    if (frame_ready) begin
                        state_nxt = S_HDR;
                        data_nxt  = HEADER;
                    end else begin
                        state_nxt = S_IDLE;
                        valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase
    end

    // Control and stream-output registers. Reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            seq       <= 8'd0;
            smp_cnt   <= '0;
            m.m_data  <= 8'd0;
            m.m_valid <= 1'b0;
            m.m_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            seq       <= seq_nxt;
            smp_cnt   <= smp_cnt_nxt;
            m.m_data  <= data_nxt;
            m.m_valid <= valid_nxt;
            m.m_last  <= last_nxt;
        end
    end

    // Checksum accumulator. This is data and is always re-seeded at the SEQ byte.
    always_ff @(posedge clk) begin
        chk_acc <= chk_nxt;
    end

endmodule

// File: doc/avg_frame_packer.md
# avg_frame_packer

Downstream stage of the moving-average filter. It captures each averaged sample qualified by the filter's output pulse into a small FIFO. Once a full frame's worth of samples is buffered, it serialises them as a byte stream with header, sequence number and checksum over a valid/ready interface. The stream feeds the UART/host link.

## Interface
- FRAME_LEN, 8: samples per frame; range 1..FIFO_DEPTH.
- FIFO_DEPTH, 16: sample FIFO depth; power of two, at least 2.
- HEADER, 8'hA5: first byte of every frame.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  allows sample capture; does not stop a frame already in progress.
- sample_valid  in  1  one-cycle strobe; connected to the filter's output_pulse.
- sample_in  in  16  signed averaged sample; connected to the filter's dout.
- m_data  out  8  stream byte.
- m_valid  out  1  stream byte valid.
- m_ready  in  1  sink ready.
- m_last  out  1  high on the checksum byte, the last byte of a frame.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of samples currently buffered.
- overflow  out  1  sticky flag: set when a sample is dropped because the FIFO is full.
- overflow_clr  in  1  clears overflow; a new drop in the same cycle wins and overflow stays set.

## Operation
- **Capture**
  - A write occurs when enable && sample_valid && fifo_level < FIFO_DEPTH.
  - If the FIFO is full, the sample is dropped and overflow is set.
  - Fullness is evaluated before any same-cycle pop, so a write arriving while full is dropped even if a pop occurs in that cycle.
  - A write and a pop in the same non-full cycle leave fifo_level unchanged.
- **FSM states:** IDLE, HDR, SEQ, HI, LO, CHK.
  - IDLE -> HDR when fifo_level >= FRAME_LEN.
  - HDR -> SEQ when the header byte is accepted.
  - SEQ -> HI when the sequence byte is accepted.
  - HI -> LO when the high byte is accepted.
  - LO -> HI when the low byte is accepted and samples remain in the frame; LO -> CHK after the FRAME_LEN-th low byte.
  - CHK -> HDR when the checksum byte is accepted and fifo_level >= FRAME_LEN; otherwise CHK -> IDLE.
- **Byte order in a frame**
  - HEADER.
  - seq (8-bit frame counter; starts at 0, increments after each CHK acceptance, wraps 255 -> 0).
  - For each sample, oldest first: sample[15:8], then sample[7:0].
  - chk.
  - Frame length is 3 + 2*FRAME_LEN bytes.
- **Checksum:** chk = (seq + sum of all data bytes) mod 256. The header is excluded.
- **FIFO pop:** a sample is popped from the FIFO on acceptance of its LO byte.
- **Handshake**
  - A byte is accepted when m_valid && m_ready.
  - Once m_valid is raised, m_data and m_last are held stable until acceptance.
  - m_valid never drops without an acceptance.
- **enable low:** new samples are ignored and overflow is not set for them. The current frame completes, and further full frames already in the FIFO are still sent.
- **Reset (including mid-frame):** the frame is abandoned, the FIFO is flushed, and seq returns to 0. Reset values: m_valid=0, m_data=0, m_last=0, overflow=0, fifo_level=0, FSM=IDLE.

## Timing
- All outputs are registered.
- fifo_level updates on the same edge as a write or pop.
- Latency from the edge that writes the FRAME_LEN-th sample to m_valid=1 carrying HEADER is 1 cycle.
- With m_ready held high, one byte is transferred per cycle. A frame takes 3 + 2*FRAME_LEN cycles.
- Back-to-back frames have no idle cycle between them: the CHK byte is followed directly by HDR.
- The next byte is presented on the edge that accepts the current one, so there are no bubbles.
- Simultaneous overflow_clr and a drop: overflow remains 1.

## Test plan
- **Basic frame:** FRAME_LEN=8; write samples 0x0001..0x0008 with m_ready=1 -> stream A5 00 00 01 00 02 00 03 00 04 00 05 00 06 00 07 00 08 24. m_last is high only on 0x24. fifo_level ends at 0.
- **Signed data and sequence wrap:** second frame of eight 0xFFFF samples -> A5 01 followed by sixteen FF bytes, then chk F1. After 256 frames, seq reads 00 again.
- **Overflow:** hold m_ready=0 and write 17 samples -> fifo_level=16 and overflow=1. The 17th sample is absent from the output. Pulse overflow_clr -> overflow=0.
- **Backpressure:** toggle m_ready pseudo-randomly during a frame -> m_data and m_last are stable while m_valid && !m_ready, and byte sequence and checksum are identical to the m_ready=1 run.
- **Back-to-back and enable:** preload 16 samples, then drop enable -> two consecutive frames of 19 bytes each with no idle cycle between them. Samples strobed while enable=0 do not change fifo_level.
- **Reset mid-frame:** assert rst_n=0 after the 5th byte -> outputs return to their reset values immediately. After release, the next frame starts with A5 00 and contains only samples written after reset.
